// File: rtl/pcie_axi_pkg.sv
// Shared definitions for the PCIe 32/64-bit AXI-stream width converters.
// Holds the dword placement within a 64-bit word, the dword keep encodings,
// the packer state encodings and the packed FIFO entry layout.
package pcie_axi_pkg;

   // The first dword of a pair goes to [63:32] and the second to [31:0].
   // The 64-to-32 RX unpacker uses the same order.
   localparam int TOP_HI = 63;
   localparam int TOP_LO = 32;
   localparam int BOT_HI = 31;
   localparam int BOT_LO = 0;

   // Dword keep encodings: bit1 covers [63:32], bit0 covers [31:0].
   localparam logic [1:0] KEEP_BOTH = 2'b11;
   localparam logic [1:0] KEEP_TOP  = 2'b10;

   // Packer states. WAIT_TOP expects the first dword of a pair.
   localparam logic [0:0] WAIT_TOP = 1'b0;
   localparam logic [0:0] WAIT_BOT = 1'b1;

   // One buffered output word, stored as {last, keep, data}.
   typedef struct packed {
      logic        last;
      logic [1:0]  keep;
      logic [63:0] data;
   } axi64_beat_t;

   localparam int BEAT_W = $bits(axi64_beat_t);

endpackage

// File: rtl/axi_sync_fifo.sv
// Single-clock register FIFO with a combinational read from the head entry.
// Ports:
//   clk, rst (async, active-low)
//   wr_en / wr_data : push. It is ignored when the FIFO is full.
//   rd_en / rd_data : pop. It is ignored when the FIFO is empty.
//                     rd_data always shows the head entry.
//   full / empty    : status derived from the registered count.
module axi_sync_fifo
   import pcie_axi_pkg::*;
#(
   parameter int DATA_WIDTH    = BEAT_W,
   parameter int ADDRESS_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]    mem_d [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic                     push;
   logic                     pop;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // NOTE: every always_comb output gets a default assignment first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      push     = wr_en && !full;
      pop      = rd_en && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         // The depth is a power of two, so the pointers wrap naturally.
         wr_ptr_d        = wr_ptr_q + ADDRESS_WIDTH'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(1);
      end
      // A simultaneous push and pop leaves the count unchanged.
      if (push && !pop) begin
         count_d = count_q + (ADDRESS_WIDTH + 1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (ADDRESS_WIDTH + 1)'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every flop samples
   // the values from before the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset. An entry is only visible once the
   // count covers it, and resetting the pointers and count empties the FIFO.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pcie_32_to_64_axi.sv
// Packs a 32-bit AXI-stream of TLP dwords into a 64-bit AXI-stream for the
// PCIe core transmit interface. A small FIFO absorbs core backpressure.
// Ports:
//   clk, rst (async, active-low)
//   i_32_data/i_32_valid/i_32_last, o_32_ready : 32-bit input stream
//   o_64_data/o_64_keep/o_64_valid/o_64_last, i_64_ready : 64-bit output stream
// Packets never share an output word, so each packet starts in [63:32].
// An odd trailing dword is sent alone with keep = 2'b10.
module pcie_32_to_64_axi
   import pcie_axi_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_32_data,
   input  logic        i_32_valid,
   input  logic        i_32_last,
   output logic        o_32_ready,
   output logic [63:0] o_64_data,
   output logic [1:0]  o_64_keep,
   output logic        o_64_valid,
   output logic        o_64_last,
   input  logic        i_64_ready
);

   logic [0:0]  state_q, state_d;
   logic [31:0] top_q, top_d;
   logic        accept;
   logic        push;
   axi64_beat_t push_beat;
   axi64_beat_t head_beat;
   logic [BEAT_W-1:0] fifo_rd_data;
   logic        fifo_full;
   logic        fifo_empty;

   // Ready is gated by full even in WAIT_TOP, where an accept does not push.
   // This keeps ready a plain registered function and costs throughput only
   // while the FIFO is full.
   assign o_32_ready = rst && !fifo_full;
   assign accept     = i_32_valid && o_32_ready;

   always_comb begin
      state_d   = state_q;
      top_d     = top_q;
      push      = 1'b0;
      push_beat = '0;
      if (accept) begin
         if (state_q == WAIT_TOP) begin
            if (i_32_last) begin
               // A lone last dword is sent by itself, left-justified.
               push                         = 1'b1;
               push_beat.data[TOP_HI:TOP_LO] = i_32_data;
               push_beat.keep               = KEEP_TOP;
               push_beat.last               = 1'b1;
            end else begin
               top_d   = i_32_data;
               state_d = WAIT_BOT;
            end
         end else begin
            push                         = 1'b1;
            push_beat.data[TOP_HI:TOP_LO] = top_q;
            push_beat.data[BOT_HI:BOT_LO] = i_32_data;
            push_beat.keep               = KEEP_BOTH;
            push_beat.last               = i_32_last;
            state_d                      = WAIT_TOP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT_TOP;
         top_q   <= '0;
      end else begin
         state_q <= state_d;
         top_q   <= top_d;
      end
   end

   axi_sync_fifo #(
      .DATA_WIDTH    (BEAT_W),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (push_beat),
      .rd_en   (i_64_ready),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign head_beat  = fifo_rd_data;
   assign o_64_valid = !fifo_empty;
   // Zero the payload while the FIFO is empty so that stale entries never
   // reach the bus, including during and after reset.
   assign o_64_data  = o_64_valid ? head_beat.data : '0;
   assign o_64_keep  = o_64_valid ? head_beat.keep : '0;
   assign o_64_last  = o_64_valid ? head_beat.last : 1'b0;

endmodule

// File: doc/pcie_32_to_64_axi.md
Name: pcie_32_to_64_axi

Overview:
- Packs a 32-bit AXI-stream into a 64-bit AXI-stream for the PCIe TX path.
- Sits directly upstream of the PCIe core's 64-bit transmit interface; fed by 32-bit TLP builders.
- Uses the same dword order as the 64-to-32 RX unpacker: the first dword of each pair goes to [63:32], the second to [31:0].
- Handles odd-length packets with a dword keep mask and buffers packed words in a small FIFO to absorb core backpressure.

Parameters:
ADDRESS_WIDTH, 2, log2 of output FIFO depth in 64-bit entries (depth = 2**ADDRESS_WIDTH, minimum 1)

Ports:
clk  input  1  single clock for all logic
rst  input  1  reset, asynchronous, active-low; clears all state immediately
i_32_data  input  32  input dword
i_32_valid  input  1  input dword valid
i_32_last  input  1  dword is the last of its packet
o_32_ready  output  1  block can accept a dword
o_64_data  output  64  packed output word
o_64_keep  output  2  dword enables: bit1 = [63:32], bit0 = [31:0]
o_64_valid  output  1  output word valid
o_64_last  output  1  output word ends the packet
i_64_ready  input  1  downstream accepts word

Behaviour:
- Reset (rst low, asynchronous):
  - state = WAIT_TOP; FIFO count, read pointer and write pointer = 0; top-holding register = 0.
  - o_32_ready = 0 while rst is low.
  - o_64_valid = 0, o_64_last = 0, o_64_keep = 0, o_64_data = 0.
- Input accept: a dword transfers when i_32_valid && o_32_ready. o_32_ready = rst deasserted && FIFO not full, derived from the registered count.
- Packer state machine:
  - WAIT_TOP, accept with last = 0: capture the dword into the top register, go to WAIT_BOT. No push.
  - WAIT_TOP, accept with last = 1: push {data, 32'h0}, keep = 2'b10, last = 1. Stay in WAIT_TOP.
  - WAIT_BOT, accept: push {top, data}, keep = 2'b11, last = i_32_last. Go to WAIT_TOP.
  - No accept: hold state.
- In WAIT_TOP, o_32_ready is still gated by full, even though the accept does not push. This keeps ready simple; the cost is one dword of throughput only when the FIFO is full.
- FIFO:
  - Register-array storage of {last, keep[1:0], data[63:0]}. Write is registered; read is combinational from the head.
  - o_64_valid = count != 0; outputs are driven from the head entry.
  - Pop when o_64_valid && i_64_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo the depth. count is ADDRESS_WIDTH+1 bits wide. full = (count == depth).
  - A push while full cannot occur because ready is deasserted.
- Latency: the second dword of a pair (or a lone last dword) is accepted at edge N; o_64_valid is high from N+1, provided the FIFO was empty.
- Throughput: with the FIFO not full and i_64_ready held high, one dword is accepted every cycle, giving one 64-bit word every two cycles.
- Packet boundaries: a packet never shares a 64-bit word with the next packet. Each new packet starts in [63:32].
- Reset mid-operation: any captured top dword and all buffered words are discarded. No partial word is emitted after reset.
- Output stability: o_64_data, o_64_keep and o_64_last hold steady while o_64_valid && !i_64_ready.

Decomposition:
- Shared package (pcie_axi_pkg): dword-order constants (TOP_DWORD = [63:32]), keep encodings KEEP_BOTH = 2'b11 and KEEP_TOP = 2'b10, and the packer state encodings WAIT_TOP = 1'b0 and WAIT_BOT = 1'b1.
- One natural sub-module, axi_sync_fifo: a parameterised register FIFO (DATA_WIDTH, ADDRESS_WIDTH) with the full/empty/count logic above, instantiated with DATA_WIDTH = 67.
- The packer FSM stays in the top level.

Test Plan:
- 4-dword packet A0..A3 (last on A3), i_64_ready = 1:
  - Two words out: {A0,A1}, keep 11, last 0; then {A2,A3}, keep 11, last 1.
  - First o_64_valid appears the cycle after A1 is accepted.
- 3-dword packet 11111111, 22222222, 33333333 (last on the third):
  - Words {11111111,22222222}, keep 11, last 0; then {33333333,00000000}, keep 10, last 1.
- Single-dword packet DEADBEEF with last, immediately followed by 2-dword packet 1,2:
  - Words {DEADBEEF,0}, keep 10, last 1; then {1,2}, keep 11, last 1. No cross-packet merge.
- i_64_ready = 0, stream 10 dwords, ADDRESS_WIDTH = 2:
  - o_32_ready drops after 8 dwords, once count = 4.
  - Raise ready: 4 words drain in order; the remaining dwords then flow with no loss or duplication.
- Drop rst low asynchronously (mid-cycle) after a top dword is captured with 2 words buffered:
  - o_64_valid = 0 and o_32_ready = 0 immediately.
  - After release, a 2-dword packet X,Y produces exactly one word {X,Y}.
- Random valid/ready over 1000 packets of length 1..64, compared against a scoreboard model:
  - Output order, keep and last match exactly.
  - Output holds stable under backpressure.
